// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width,
// opcode encodings and the sequencing FSM states.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SHL  = 3'd5;
    localparam logic [2:0] ALU_SHR  = 3'd6;
    localparam logic [2:0] ALU_PASS = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two request channels and the response channel.
// master: the requesters and response consumer; slave: the arbiter.
interface alu_arbiter_if #(
    parameter int DATA_W = alu_pkg::DATA_W
);
    import alu_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [2:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [2:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_greater;
    logic              rsp_less;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_greater, rsp_less,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_greater, rsp_less,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: result plus zero / unsigned compare-against-B flags.
module alu_core #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              greater,
    output logic              less
);
    import alu_pkg::*;

    localparam int SH_W = $clog2(DATA_W);

    // Any set bit above the shift-amount field means the shift is >= DATA_W.
    logic shift_oob;
    assign shift_oob = |b[DATA_W-1:SH_W];

    // Opcode decode; out-of-range shifts flush to zero.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SHL:  result = shift_oob ? '0 : (a << b[SH_W-1:0]);
            ALU_SHR:  result = shift_oob ? '0 : (a >> b[SH_W-1:0]);
            ALU_PASS: result = a;
            default:  result = a;
        endcase
    end

    assign zero    = (result == '0);
    assign greater = (result > b);
    assign less    = (result < b);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Accepts one request in IDLE, evaluates it in EXEC, holds the response in RESP.
module alu_arbiter #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    import alu_pkg::*;

    state_t            state_reg;
    state_t            state_next;
    logic              last_id_reg;

    // Operands captured at the request handshake.
    logic              id_reg;
    logic [2:0]        op_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;

    // Response registers, loaded in EXEC.
    logic              rsp_id_reg;
    logic [DATA_W-1:0] rsp_result_reg;
    logic              rsp_zero_reg;
    logic              rsp_greater_reg;
    logic              rsp_less_reg;

    // Per-requester views of the request channels.
    logic [1:0]        valid;
    logic [1:0]        ready;
    logic [2:0]        req_op [2];
    logic [DATA_W-1:0] req_a  [2];
    logic [DATA_W-1:0] req_b  [2];

    logic              grant;
    logic              accept_en;
    logic              handshake;
    logic              load_rsp;

    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_greater;
    logic              alu_less;

    assign valid[0]  = bus.req0_valid;
    assign valid[1]  = bus.req1_valid;
    assign req_op[0] = bus.req0_op;
    assign req_op[1] = bus.req1_op;
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;

    // Contention goes to whoever was not served last; otherwise the lone valid one.
    assign grant     = (&valid) ? ~last_id_reg : valid[1];
    assign accept_en = (state_reg == S_IDLE) && !rst;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = accept_en && valid[gi] && (grant == 1'(gi));
        end
    endgenerate

    assign handshake = |ready;

    // State register; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and EXEC load strobe.
    always_comb begin
        state_next = state_reg;
        load_rsp   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (handshake) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                load_rsp   = 1'b1;
                state_next = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Capture the granted request and remember who was served.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_id_reg <= 1'b1;
            id_reg      <= 1'b0;
            op_reg      <= ALU_ADD;
            a_reg       <= '0;
            b_reg       <= '0;
        end else if (handshake) begin
            last_id_reg <= grant;
            id_reg      <= grant;
            op_reg      <= req_op[grant];
            a_reg       <= req_a[grant];
            b_reg       <= req_b[grant];
        end
    end

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .op      (op_reg),
        .a       (a_reg),
        .b       (b_reg),
        .result  (alu_result),
        .zero    (alu_zero),
        .greater (alu_greater),
        .less    (alu_less)
    );

    // Register ALU output in EXEC; fields then hold until the next op.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id_reg      <= 1'b0;
            rsp_result_reg  <= '0;
            rsp_zero_reg    <= 1'b0;
            rsp_greater_reg <= 1'b0;
            rsp_less_reg    <= 1'b0;
        end else if (load_rsp) begin
            rsp_id_reg      <= id_reg;
            rsp_result_reg  <= alu_result;
            rsp_zero_reg    <= alu_zero;
            rsp_greater_reg <= alu_greater;
            rsp_less_reg    <= alu_less;
        end
    end

    assign bus.req0_ready  = ready[0];
    assign bus.req1_ready  = ready[1];
    assign bus.rsp_valid   = (state_reg == S_RESP);
    assign bus.rsp_id      = rsp_id_reg;
    assign bus.rsp_result  = rsp_result_reg;
    assign bus.rsp_zero    = rsp_zero_reg;
    assign bus.rsp_greater = rsp_greater_reg;
    assign bus.rsp_less    = rsp_less_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: queue-driven requesters, a cycle-level reference
// model checked every cycle, and directed literal checks per scenario.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    op_t  q0[$];
    op_t  q1[$];
    logic hs0 = 1'b0;
    logic hs1 = 1'b0;

    // Reference model state.
    logic        m_busy   = 1'b0;
    logic        m_exec   = 1'b0;
    logic        m_last   = 1'b1;
    logic        rst_prev = 1'b1;  // rst is high from time 0
    logic        m_id     = 1'b0;
    logic [31:0] m_res    = '0;
    logic [31:0] m_b      = '0;
    int          discards = 0;

    // Log of responses taken by the consumer.
    logic        log_id[$];
    logic [31:0] log_res[$];
    logic        log_zero[$];
    logic        log_gt[$];
    logic        log_lt[$];

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(32)) bus ();

    alu_arbiter #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", name, got, exp);
        end
    endtask

    function automatic op_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.op = op;
        o.a  = a;
        o.b  = b;
        return o;
    endfunction

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (b >= 32) ? 32'd0 : (a << b);
            3'd6: return (b >= 32) ? 32'd0 : (a >> b);
            default: return a;
        endcase
    endfunction

    // Per-cycle check of every DUT output against the model.
    always @(negedge clk) begin
        logic er0;
        logic er1;
        if (rst) begin
            chk1("rst_ready0", bus.req0_ready, 1'b0);
            chk1("rst_ready1", bus.req1_ready, 1'b0);
            if (rst_prev) begin
                chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
                chk1("rst_rsp_id", bus.rsp_id, 1'b0);
                chk("rst_rsp_result", bus.rsp_result, 32'd0);
                chk1("rst_rsp_zero", bus.rsp_zero, 1'b0);
                chk1("rst_rsp_greater", bus.rsp_greater, 1'b0);
                chk1("rst_rsp_less", bus.rsp_less, 1'b0);
            end
            if (m_busy) discards++;
            m_busy = 1'b0;
            m_exec = 1'b0;
            m_last = 1'b1;
        end else begin
            er0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
            er1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
            chk1("ready0", bus.req0_ready, er0);
            chk1("ready1", bus.req1_ready, er1);
            if (!m_busy) begin
                chk1("idle_rsp_valid", bus.rsp_valid, 1'b0);
                if (er0 || er1) begin
                    m_id   = er1;
                    m_b    = er1 ? bus.req1_b : bus.req0_b;
                    m_res  = er1 ? alu_model(bus.req1_op, bus.req1_a, bus.req1_b)
                                 : alu_model(bus.req0_op, bus.req0_a, bus.req0_b);
                    m_busy = 1'b1;
                    m_exec = 1'b1;
                    m_last = er1;
                end
            end else if (m_exec) begin
                chk1("exec_rsp_valid", bus.rsp_valid, 1'b0);
                m_exec = 1'b0;
            end else begin
                chk1("rsp_valid", bus.rsp_valid, 1'b1);
                chk1("rsp_id", bus.rsp_id, m_id);
                chk("rsp_result", bus.rsp_result, m_res);
                chk1("rsp_zero", bus.rsp_zero, m_res == 32'd0);
                chk1("rsp_greater", bus.rsp_greater, m_res > m_b);
                chk1("rsp_less", bus.rsp_less, m_res < m_b);
                if (bus.rsp_ready) begin
                    log_id.push_back(bus.rsp_id);
                    log_res.push_back(bus.rsp_result);
                    log_zero.push_back(bus.rsp_zero);
                    log_gt.push_back(bus.rsp_greater);
                    log_lt.push_back(bus.rsp_less);
                    $display("rsp #%0d id=%0d result=%h z=%b g=%b l=%b", log_id.size(),
                             bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_greater,
                             bus.rsp_less);
                    m_busy = 1'b0;
                end
            end
        end
        rst_prev = rst;
        hs0 = bus.req0_ready && bus.req0_valid;
        hs1 = bus.req1_ready && bus.req1_valid;
    end

    task automatic drive();
        bus.req0_valid = (q0.size() > 0);
        bus.req0_op    = (q0.size() > 0) ? q0[0].op : 3'd0;
        bus.req0_a     = (q0.size() > 0) ? q0[0].a  : 32'd0;
        bus.req0_b     = (q0.size() > 0) ? q0[0].b  : 32'd0;
        bus.req1_valid = (q1.size() > 0);
        bus.req1_op    = (q1.size() > 0) ? q1[0].op : 3'd0;
        bus.req1_a     = (q1.size() > 0) ? q1[0].a  : 32'd0;
        bus.req1_b     = (q1.size() > 0) ? q1[0].b  : 32'd0;
    endtask

    // One clock: retire handshaken requests, then present the next heads.
    task automatic step();
        @(posedge clk);
        #1;
        if (hs0 && q0.size() > 0) q0.delete(0);
        if (hs1 && q1.size() > 0) q1.delete(0);
        drive();
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int i = 0;
        while (log_id.size() < n && i < budget) begin
            step();
            i++;
        end
        chk(name, 32'(log_id.size()), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int i;
        bus.rsp_ready = 1'b1;

        // 1: reset, then a single ADD from requester 0.
        q0.push_back(mk(ALU_ADD, 32'd5, 32'd1));
        drive();
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("t1_ready0_first_idle", bus.req0_ready, 1'b1);
        step();
        @(negedge clk);
        chk1("t1_exec_no_valid", bus.rsp_valid, 1'b0);
        step();
        @(negedge clk);
        chk1("t1_valid_n_plus_2", bus.rsp_valid, 1'b1);
        chk("t1_result", bus.rsp_result, 32'd6);
        chk1("t1_id", bus.rsp_id, 1'b0);
        chk1("t1_zero", bus.rsp_zero, 1'b0);
        chk1("t1_greater", bus.rsp_greater, 1'b1);
        wait_log(1, 10, "t1_count");

        // 2: contention straight out of reset.
        rst = 1'b1;
        q0.push_back(mk(ALU_AND, 32'hFF, 32'h0F));
        q1.push_back(mk(ALU_SUB, 32'd255, 32'd255));
        drive();
        step();
        step();
        rst = 1'b0;
        n = log_id.size();
        wait_log(n + 2, 20, "t2_count");
        chk1("t2_first_id", log_id[n], 1'b0);
        chk("t2_and_result", log_res[n], 32'h0F);
        chk1("t2_second_id", log_id[n+1], 1'b1);
        chk("t2_sub_result", log_res[n+1], 32'd0);
        chk1("t2_sub_zero", log_zero[n+1], 1'b1);
        chk1("t2_sub_less", log_lt[n+1], 1'b1);
        chk1("t2_sub_greater", log_gt[n+1], 1'b0);

        // 3: backpressure with requester 1 waiting.
        bus.rsp_ready = 1'b0;
        q0.push_back(mk(ALU_OR, 32'hF0, 32'h0F));
        q1.push_back(mk(ALU_XOR, 32'd3, 32'd5));
        drive();
        i = 0;
        while (!bus.rsp_valid && i < 20) begin
            step();
            @(negedge clk);
            i++;
        end
        chk1("t3_rsp_seen", bus.rsp_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk1("t3_hold_valid", bus.rsp_valid, 1'b1);
            chk("t3_hold_result", bus.rsp_result, 32'hFF);
            chk1("t3_hold_id", bus.rsp_id, 1'b0);
            chk1("t3_hold_ready0", bus.req0_ready, 1'b0);
            chk1("t3_hold_ready1", bus.req1_ready, 1'b0);
        end
        step();
        bus.rsp_ready = 1'b1;
        step();
        @(negedge clk);
        chk1("t3_next_grant", bus.req1_ready, 1'b1);
        n = log_id.size();
        wait_log(n + 1, 10, "t3_count");
        chk("t3_xor_result", log_res[n], 32'd6);

        // 4: arithmetic edges.
        q0.push_back(mk(ALU_ADD, 32'hFFFF_FFFF, 32'd1));
        q0.push_back(mk(ALU_SHL, 32'd1, 32'd32));
        q0.push_back(mk(ALU_SHR, 32'h8000_0000, 32'd31));
        q0.push_back(mk(ALU_PASS, 32'hFF, 32'hFF));
        drive();
        n = log_id.size();
        wait_log(n + 4, 30, "t4_count");
        chk("t4_add_wrap", log_res[n], 32'd0);
        chk1("t4_add_zero", log_zero[n], 1'b1);
        chk("t4_shl_oob", log_res[n+1], 32'd0);
        chk("t4_shr_31", log_res[n+2], 32'd1);
        chk("t4_pass", log_res[n+3], 32'hFF);
        chk1("t4_pass_zero", log_zero[n+3], 1'b0);
        chk1("t4_pass_greater", log_gt[n+3], 1'b0);
        chk1("t4_pass_less", log_lt[n+3], 1'b0);

        // 5: reset while the op is in EXEC; requester 1 pending.
        q0.push_back(mk(ALU_ADD, 32'd2, 32'd6));
        drive();
        n = log_id.size();
        i = 0;
        while (q0.size() != 0 && i < 20) begin
            step();
            i++;
        end
        chk("t5_req0_taken", 32'(q0.size()), 32'd0);
        q1.push_back(mk(ALU_SUB, 32'd9, 32'd4));
        rst = 1'b1;
        drive();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("t5_no_rsp_after_rst", bus.rsp_valid, 1'b0);
        chk1("t5_ready1_after_rst", bus.req1_ready, 1'b1);
        wait_log(n + 1, 10, "t5_count");
        step();
        step();
        chk("t5_exact_count", 32'(log_id.size()), 32'(n + 1));
        chk1("t5_id", log_id[n], 1'b1);
        chk("t5_result", log_res[n], 32'd5);

        // 6: both requesters saturated for 20 ops.
        for (int k = 0; k < 10; k++) begin
            q0.push_back(mk(3'(k % 8), 32'(k * 3 + 1), 32'(k)));
            q1.push_back(mk(3'((k + 3) % 8), 32'hF0F0_0000 + 32'(k), 32'(k + 1)));
        end
        drive();
        n = log_id.size();
        wait_log(n + 20, 200, "t6_count");
        for (int k = 0; k < 20; k++) begin
            chk1("t6_alternate", log_id[n+k], 1'(k % 2));
        end
        step();
        step();
        step();
        chk("t6_no_dup", 32'(log_id.size()), 32'(n + 20));
        chk("t6_q0_drained", 32'(q0.size()), 32'd0);
        chk("t6_q1_drained", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
